// File: rtl/marc_bus_pkg.sv
// Shared types and constants for the mARC memory bus interface unit.
package marc_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DONE = 2'd3
  } bus_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // One posted write waiting in the write buffer
  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/mem_bus_interface_if.sv
// Core-side and memory-side signals of the bus interface unit.
interface mem_bus_interface_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WBUF_DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic              core_req;
  logic              core_rw;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              core_err;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  wbuf_count;

  // Bus interface unit view: owns all main-memory traffic
  modport master (
    input  core_req, core_rw, core_addr, core_wdata, mem_ack, mem_rdata,
    output core_rdata, core_stall, core_err, mem_req, mem_rw, mem_addr,
           mem_wdata, wbuf_count
  );

  // Core plus memory view, the counterpart of master
  modport slave (
    output core_req, core_rw, core_addr, core_wdata, mem_ack, mem_rdata,
    input  core_rdata, core_stall, core_err, mem_req, mem_rw, mem_addr,
           mem_wdata, wbuf_count
  );

endinterface

// File: rtl/wbuf_fifo.sv
// Synchronous in-order FIFO used as the posted-write buffer.
module wbuf_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full buffer refuses a push even when a pop happens in the same cycle
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = store[rd_ptr];

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset flushes the buffer
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_interface.sv
// Bus interface unit: posted write buffer, read handshake, core stall and watchdog.
module mem_bus_interface
  import marc_bus_pkg::*;
#(
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                 clk,
  input logic                 reset,
  mem_bus_interface_if.master bus
);

  localparam int unsigned CNT_W   = $clog2(WBUF_DEPTH) + 1;
  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          WD_ON   = (TIMEOUT > 0);

  localparam logic [1:0] IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] WR_REQ  = 2'(ST_WR_REQ);
  localparam logic [1:0] RD_REQ  = 2'(ST_RD_REQ);
  localparam logic [1:0] RD_DONE = 2'(ST_RD_DONE);

  logic [1:0]        state, state_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              mem_req_q, mem_req_nxt;
  logic              mem_rw_q, mem_rw_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_nxt;
  logic              core_err_q, core_err_nxt;

  logic              push_c;
  logic              pop_c;
  logic              expired_c;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  wbuf_cnt;
  wbuf_entry_t       ent_in;
  wbuf_entry_t       head;

  assign ent_in.addr = BUS_ADDR_W'(bus.core_addr);
  assign ent_in.data = BUS_DATA_W'(bus.core_wdata);
  assign push_c      = bus.core_req & (bus.core_rw == RW_WRITE) & ~full;
  assign expired_c   = WD_ON && (wd_cnt == WD_W'(WD_LAST));

  wbuf_fifo #(
    .WIDTH ($bits(wbuf_entry_t)),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (ent_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (wbuf_cnt)
  );

  // Next-state, request outputs and watchdog; buffered writes drain before any read
  always_comb begin
    state_nxt      = state;
    wd_cnt_nxt     = wd_cnt;
    mem_req_nxt    = mem_req_q;
    mem_rw_nxt     = mem_rw_q;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;
    core_rdata_nxt = core_rdata_q;
    core_err_nxt   = 1'b0;
    pop_c          = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt     = WR_REQ;
          mem_req_nxt   = 1'b1;
          mem_rw_nxt    = RW_WRITE;
          mem_addr_nxt  = ADDR_W'(head.addr);
          mem_wdata_nxt = DATA_W'(head.data);
          wd_cnt_nxt    = '0;
        end else if (bus.core_req && (bus.core_rw == RW_READ)) begin
          state_nxt    = RD_REQ;
          mem_req_nxt  = 1'b1;
          mem_rw_nxt   = RW_READ;
          mem_addr_nxt = bus.core_addr;
          wd_cnt_nxt   = '0;
        end
      end
      WR_REQ: begin
        if (bus.mem_ack || expired_c) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          pop_c        = 1'b1;
          core_err_nxt = ~bus.mem_ack;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      RD_REQ: begin
        if (bus.mem_ack) begin
          state_nxt      = RD_DONE;
          mem_req_nxt    = 1'b0;
          core_rdata_nxt = bus.mem_rdata;
        end else if (expired_c) begin
          state_nxt      = RD_DONE;
          mem_req_nxt    = 1'b0;
          core_rdata_nxt = '1;
          core_err_nxt   = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      RD_DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      mem_req_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      wd_cnt       <= wd_cnt_nxt;
      mem_req_q    <= mem_req_nxt;
      mem_rw_q     <= mem_rw_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_wdata_q  <= mem_wdata_nxt;
      core_rdata_q <= core_rdata_nxt;
      core_err_q   <= core_err_nxt;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.core_err   = core_err_q;
  assign bus.wbuf_count = wbuf_cnt;

  // Reads release the core only in RD_DONE; writes only wait on a full buffer
  assign bus.core_stall = ~reset |
                          (bus.core_req & ((bus.core_rw & full) |
                                           (~bus.core_rw & (state != RD_DONE))));

endmodule

// File: tb/tb_mem_bus_interface.sv
// Randomized and directed bench for mem_bus_interface with a program-order memory model.
`timescale 1ns/1ps
module tb_mem_bus_interface;
  import marc_bus_pkg::*;

  localparam int unsigned DW = 16, AW = 16, DEPTH = 4, TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_interface_if #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(DEPTH)) bus ();

  mem_bus_interface #(
    .DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [15:0] ram     [256];
  logic [15:0] exp_mem [256];

  int errs = 0, checks = 0;
  bit ack_en = 1'b1, rand_mode = 1'b0;
  int cur_delay = 0, wait_cnt = 0;
  int run = 0, last_run = 0, req_total = 0, proto_err = 0;
  bit prev_req = 1'b0, prev_ack = 1'b0, prev_done = 1'b0;
  logic        prev_rw;
  logic [15:0] prev_addr, prev_wdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model and protocol monitor, sampled at the active edge
  always @(posedge clk) begin
    if (bus.mem_req === 1'b1) begin
      req_total++;
      run++;
      if (prev_done) proto_err++;
      if (prev_req && !prev_ack &&
          (bus.mem_rw !== prev_rw || bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata))
        proto_err++;
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    prev_done  = (bus.mem_req === 1'b1) && (bus.mem_ack === 1'b1);
    prev_req   = (bus.mem_req === 1'b1);
    prev_ack   = (bus.mem_ack === 1'b1);
    prev_rw    = bus.mem_rw;
    prev_addr  = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
    if (prev_done) begin
      txn_t t;
      t.rw   = bus.mem_rw;
      t.addr = bus.mem_addr;
      t.data = bus.mem_rw ? bus.mem_wdata : bus.mem_rdata;
      obs_q.push_back(t);
      if (bus.mem_rw) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
      wait_cnt  = 0;
      if (rand_mode) cur_delay = int'($urandom_range(0, 2));
    end else if (prev_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  end

  // Memory responder drives ack/data away from the active edge
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1 && ack_en && wait_cnt >= cur_delay) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bus.mem_rw ? 16'($urandom) : ram[bus.mem_addr[7:0]];
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
    end
  end

  task automatic core_op(input logic rw, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic err, output int stalls);
    @(negedge clk);
    bus.core_req   = 1'b1;
    bus.core_rw    = rw;
    bus.core_addr  = a;
    bus.core_wdata = d;
    stalls = 0;
    #1;
    while (bus.core_stall !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 100) check_val("op_timeout", 64'd1, 64'd0);
    rd  = bus.core_rdata;
    err = bus.core_err;
    @(posedge clk);
  endtask

  task automatic core_idle();
    @(negedge clk);
    bus.core_req = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(negedge clk);
      #1;
      if (bus.wbuf_count == 0 && bus.mem_req == 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check_val("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, a, d;
    logic        err, rw;
    int          st, st5, snap_req, snap_obs;
    txn_t        t;

    bus.core_req   = 1'b0;
    bus.core_rw    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_mem_req",    64'(bus.mem_req), 64'd0);
    check_val("rst_mem_rw",     64'(bus.mem_rw), 64'd0);
    check_val("rst_mem_addr",   64'(bus.mem_addr), 64'd0);
    check_val("rst_mem_wdata",  64'(bus.mem_wdata), 64'd0);
    check_val("rst_core_rdata", 64'(bus.core_rdata), 64'd0);
    check_val("rst_core_err",   64'(bus.core_err), 64'd0);
    check_val("rst_wbuf_count", 64'(bus.wbuf_count), 64'd0);
    check_val("rst_core_stall", 64'(bus.core_stall), 64'd1);
    reset = 1'b1;

    // Zero-wait read
    ram[8'h40] = 16'hBEEF;
    core_op(RW_READ, 16'h0040, 16'h0, rd, err, st);
    check_val("rd0_stall", 64'(st), 64'd2);
    check_val("rd0_data", 64'(rd), 64'hBEEF);
    core_idle();
    check_val("rd0_req_cycles", 64'(last_run), 64'd1);

    // Five back-to-back writes with ack held off
    obs_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_op(RW_WRITE, 16'(16'h10 + i), 16'(16'hA0 + i), rd, err, st);
      check_val($sformatf("wr%0d_stall", i), 64'(st), 64'd0);
    end
    #1;
    check_val("wbuf_full_count", 64'(bus.wbuf_count), 64'd4);
    fork
      core_op(RW_WRITE, 16'h14, 16'hA4, rd, err, st5);
      begin @(negedge clk); #2; ack_en = 1'b1; end
    join
    check_val("wr4_stall", 64'(st5), 64'd2);
    core_idle();
    drain();
    check_val("wr_burst_len", 64'(obs_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++)
      check_val($sformatf("wr_burst_%0d", i), 64'(obs_q[i]),
                64'({1'b1, 16'(16'h10 + i), 16'(16'hA0 + i)}));

    // Write then read of the same address
    obs_q.delete();
    core_op(RW_WRITE, 16'h0020, 16'h1234, rd, err, st);
    core_op(RW_READ, 16'h0020, 16'h0, rd, err, st);
    check_val("raw_data", 64'(rd), 64'h1234);
    core_idle();
    drain();
    check_val("raw_len", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check_val("raw_first", 64'(obs_q[0]), 64'({1'b1, 16'h0020, 16'h1234}));
      check_val("raw_second", 64'(obs_q[1]), 64'({1'b0, 16'h0020, 16'h1234}));
    end

    // Read with three wait states
    cur_delay = 3;
    ram[8'h44] = 16'h5A5A;
    core_op(RW_READ, 16'h0044, 16'h0, rd, err, st);
    check_val("rd3_stall", 64'(st), 64'd5);
    check_val("rd3_data", 64'(rd), 64'h5A5A);
    core_idle();
    check_val("rd3_req_cycles", 64'(last_run), 64'd4);
    cur_delay = 0;

    // Watchdog abort of a never-acked read
    ack_en = 1'b0;
    snap_obs = obs_q.size();
    core_op(RW_READ, 16'h0030, 16'h0, rd, err, st);
    check_val("tmo_stall", 64'(st), 64'(TMO + 1));
    check_val("tmo_rdata", 64'(rd), 64'hFFFF);
    check_val("tmo_err_pulse", 64'(err), 64'd1);
    core_idle();
    #1;
    check_val("tmo_err_clear", 64'(bus.core_err), 64'd0);
    check_val("tmo_req_cycles", 64'(last_run), 64'(TMO));
    check_val("tmo_idle_req", 64'(bus.mem_req), 64'd0);
    check_val("tmo_no_txn", 64'(obs_q.size()), 64'(snap_obs));

    // Reset during a read request with two writes buffered
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_rw = RW_READ; bus.core_addr = 16'h0050;
    @(negedge clk);
    bus.core_rw = RW_WRITE; bus.core_addr = 16'h0060; bus.core_wdata = 16'h0001;
    @(negedge clk);
    bus.core_addr = 16'h0061; bus.core_wdata = 16'h0002;
    @(negedge clk);
    bus.core_req = 1'b0;
    #1;
    check_val("pre_rst_req", 64'(bus.mem_req), 64'd1);
    check_val("pre_rst_count", 64'(bus.wbuf_count), 64'd2);
    reset = 1'b0;
    #1;
    check_val("rst_forced_stall", 64'(bus.core_stall), 64'd1);
    @(negedge clk); #1;
    check_val("mid_rst_req", 64'(bus.mem_req), 64'd0);
    check_val("mid_rst_count", 64'(bus.wbuf_count), 64'd0);
    check_val("mid_rst_rdata", 64'(bus.core_rdata), 64'd0);
    reset = 1'b1;
    ack_en = 1'b1;
    snap_req = req_total;
    snap_obs = obs_q.size();
    repeat (10) @(negedge clk);
    check_val("post_rst_quiet_req", 64'(req_total), 64'(snap_req));
    check_val("post_rst_quiet_txn", 64'(obs_q.size()), 64'(snap_obs));

    // Random traffic against the program-order model
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_mem[i] = ram[i];
    rand_mode = 1'b1;
    cur_delay = int'($urandom_range(0, 2));
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 16'(16'h80 + $urandom_range(0, 7));
      d  = 16'($urandom);
      core_op(rw, a, d, rd, err, st);
      t.rw = rw;
      t.addr = a;
      if (rw) begin
        exp_mem[a[7:0]] = d;
        t.data = d;
      end else begin
        t.data = exp_mem[a[7:0]];
        check_val($sformatf("rand_rd_%0d", n), 64'(rd), 64'(exp_mem[a[7:0]]));
      end
      exp_q.push_back(t);
      if ($urandom_range(0, 3) == 0) core_idle();
    end
    core_idle();
    drain();
    check_val("rand_len", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_val($sformatf("rand_order_%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    check_val("protocol", 64'(proto_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Parametrised bus interface unit between the mARC processor core and main memory. Replaces the core's fixed single-cycle memory assumption with a request/acknowledge memory handshake and core stalls. Writes are posted into a small in-order write buffer, reads drain that buffer first, and a watchdog aborts transactions that are never acknowledged. It instantiates beside the Processor top and owns all main-memory traffic.

## Interface
- DATA_W, 16: data width, in bits.
- ADDR_W, 16: address width, in bits.
- WBUF_DEPTH, 4: write-buffer entries; must be a power of 2 and ≥2.
- TIMEOUT, 255: maximum request cycles without an ack before abort; 0 disables the watchdog.

- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- core_req  in  1  core access request; held while core_stall is high.
- core_rw  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  access address; stable while core_req is high.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  read data; valid when a read completes.
- core_stall  out  1  core must hold its state.
- core_err  out  1  one-cycle pulse after a timed-out transaction.
- mem_req  out  1  memory request.
- mem_rw  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory acknowledge; sampled at the rising edge.
- mem_rdata  in  DATA_W  memory read data; valid while mem_ack is high.
- wbuf_count  out  clog2(WBUF_DEPTH)+1  current write-buffer occupancy.

## Operation
- The FSM has four states: IDLE, WR_REQ, RD_REQ, RD_DONE.
- IDLE:
  - If the buffer is non-empty, go to WR_REQ (writes have priority).
  - Else if core_req=1 and core_rw=0, latch core_addr and go to RD_REQ.
- WR_REQ:
  - mem_req=1, mem_rw=1, with the head entry on mem_addr and mem_wdata.
  - On mem_ack: pop the entry and go to IDLE.
- RD_REQ:
  - mem_req=1, mem_rw=0, with the latched address on mem_addr.
  - On mem_ack: capture mem_rdata into core_rdata and go to RD_DONE.
- RD_DONE: core_stall=0 for this cycle; go to IDLE.
- Write acceptance:
  - A write is pushed at the clock edge when core_req=1, core_rw=1 and the buffer is not full.
  - Pushes are accepted in any state.
  - A full buffer stalls the write, even in a cycle where a pop is occurring.
- core_stall = core_req & ((core_rw & full) | (~core_rw & state≠RD_DONE)). It is forced to 1 while reset is low.
- Ordering: reads never bypass buffered writes. The memory sees all accesses in core program order.
- Handshake rules:
  - mem_req, mem_rw, mem_addr and mem_wdata stay stable from request assertion until the edge that samples mem_ack=1.
  - mem_req is low for at least one cycle between transactions.
  - mem_ack is ignored in IDLE and RD_DONE.
- Watchdog:
  - The counter clears on entry to WR_REQ or RD_REQ and increments on each request cycle without an ack.
  - When mem_req has been high for TIMEOUT cycles without an ack, the transaction aborts:
    - a write entry is discarded (popped);
    - a read returns all-ones on core_rdata via RD_DONE.
  - core_err pulses in the cycle after the abort.
  - If mem_ack arrives on the same cycle the count expires, the ack wins.
- Reset applied mid-operation: at the next edge the state returns to IDLE, mem_req drops, and the buffer is flushed (posted writes are lost).

## Timing
- Reset values: mem_req 0, mem_rw 0, mem_addr 0, mem_wdata 0, core_rdata 0, core_err 0, wbuf_count 0. FSM starts in IDLE.
- Read latency, empty buffer, zero wait states: core_stall is high for 2 cycles; data is valid in the 3rd cycle (RD_DONE). Each memory wait state adds 1 cycle.
- Read behind N buffered writes: the read is delayed by each write's handshake time plus 1 IDLE cycle per write.
- Posted write: 0 stall cycles while the buffer is not full.
- Minimum memory throughput: 1 transaction every 2 cycles.

## Structure
- Package marc_bus_pkg holds:
  - the state enum (IDLE, WR_REQ, RD_REQ, RD_DONE);
  - RW_READ=0 and RW_WRITE=1;
  - the write-buffer entry struct {addr, data}.
- Sub-module wbuf_fifo: synchronous FIFO parametrised by width and depth, with push, pop, full, empty and count.
- The FSM, watchdog and stall logic live in mem_bus_interface.

## Test plan
- Zero-wait read of 0x0040 with mem_rdata=0xBEEF acked in the first request cycle → core_stall high 2 cycles, core_rdata=0xBEEF in cycle 3, mem_req high exactly 1 cycle.
- Five back-to-back writes to 0x10..0x14 (data 0xA0..0xA4), mem_ack held low → first four accepted with no stall, wbuf_count=4, fifth write stalls. After ack release, memory sees 0x10..0x14 in order.
- Write 0x20←0x1234 then read 0x20 → the memory write handshake completes before mem_req for the read rises; core_rdata equals mem_rdata from that read.
- Read with mem_ack delayed 3 cycles → mem_req and mem_addr stable for 4 cycles, core_stall high 5 cycles.
- TIMEOUT=8, read never acked → mem_req high exactly 8 cycles, core_err pulses 1 cycle, core_rdata=0xFFFF, FSM back in IDLE.
- Reset pulled low during RD_REQ with 2 buffered writes → next edge: mem_req=0, wbuf_count=0, core_rdata=0, and no memory traffic after reset releases until a new core_req.
